// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: ALU op/class codes, bus widths, divider states.
// No logic of its own; pure constants, types and one helper.
// Imported by ex and div.
package ex_pkg;

   localparam int REG_BUS_W  = 32;
   localparam int REG_ADDR_W = 5;
   localparam int ALU_OP_W   = 8;
   localparam int ALU_SEL_W  = 3;

   localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

   // ALU operation codes from decode
   localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
   localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [ALU_OP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [ALU_OP_W-1:0] EXE_ADD_OP  = 8'b0010_0000;
   localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
   localparam logic [ALU_OP_W-1:0] EXE_SUB_OP  = 8'b0010_0010;
   localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP = 8'b0010_0011;
   localparam logic [ALU_OP_W-1:0] EXE_SLT_OP  = 8'b0010_1010;
   localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP = 8'b0010_1011;
   localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

   // Result classes
   localparam logic [ALU_SEL_W-1:0] SEL_NOP   = 3'b000;
   localparam logic [ALU_SEL_W-1:0] SEL_LOGIC = 3'b001;
   localparam logic [ALU_SEL_W-1:0] SEL_SHIFT = 3'b010;
   localparam logic [ALU_SEL_W-1:0] SEL_ARITH = 3'b100;
   localparam logic [ALU_SEL_W-1:0] SEL_DIV   = 3'b101;

   // Divider FSM states
   typedef enum logic [1:0] {
      DIV_IDLE    = 2'b00,
      DIV_DIVZERO = 2'b01,
      DIV_BUSY    = 2'b10,
      DIV_DONE    = 2'b11
   } div_state_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   typedef struct packed {
      logic [REG_BUS_W-1:0] hi;
      logic [REG_BUS_W-1:0] lo;
   } hilo_t;

   // Magnitude of a value that is two's complement only when sgn is set
   function automatic logic [REG_BUS_W-1:0] mag(input logic sgn, input logic [REG_BUS_W-1:0] v);
      return (sgn && v[REG_BUS_W-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, signed or unsigned, result {remainder, quotient}.
// Latency: 33 cycles start-to-ready (2 for a zero divisor); ready lasts one cycle.
// No backpressure: caller holds operands/start until ready; annul or rst abandon at once.
module div
   import ex_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_t  state;
   logic [4:0]  cnt;
   logic [31:0] rem;
   logic [31:0] quo;     // dividend bits shift out the top, quotient bits shift in
   logic [31:0] dvs;
   logic        neg_q;
   logic        neg_r;
   hilo_t       res_q;

   logic [32:0] trial;
   logic        fits;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;

   // One restoring step: bring down the next dividend bit and try to subtract
   always_comb begin
      trial   = {rem, quo[31]};
      fits    = (trial >= {1'b0, dvs});
      rem_nxt = fits ? (trial[31:0] - dvs) : trial[31:0];
      quo_nxt = {quo[30:0], fits};
   end

   // Divider FSM: latch operands, iterate 32 steps, apply signs into the result register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DIV_IDLE;
         cnt   <= '0;
         rem   <= ZERO_WORD;
         quo   <= ZERO_WORD;
         dvs   <= ZERO_WORD;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         res_q <= '0;
      end else if (annul_i) begin
         state <= DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i) begin
                  if (op2_i == ZERO_WORD) begin
                     state <= DIV_DIVZERO;
                  end else begin
                     quo   <= mag(signed_i, op1_i);
                     dvs   <= mag(signed_i, op2_i);
                     rem   <= ZERO_WORD;
                     neg_q <= signed_i && (op1_i[31] ^ op2_i[31]);
                     neg_r <= signed_i && op1_i[31];
                     cnt   <= '0;
                     state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  res_q.lo <= neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
                  res_q.hi <= neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
                  state    <= DIV_DONE;
               end
            end
            DIV_DIVZERO: begin
               res_q <= '0;
               state <= DIV_DONE;
            end
            DIV_DONE: begin
               state <= DIV_IDLE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   assign result_o = res_q;
   // A flush or reset in the DONE cycle suppresses the result
   assign ready_o  = (!rst && !annul_i && state == DIV_DONE) ? DIV_RESULT_READY
                                                             : DIV_RESULT_NOT_READY;

endmodule

// File: rtl/ex.sv
// Execute stage: logic/shift/arith ALU plus HI/LO write-back from the divider.
// Latency: ALU ops same cycle; DIV/DIVU 33 cycles (2 for divide by zero).
// Backpressure: raises stallreq_o while a divide is outstanding; inputs must hold.
module ex
   import ex_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ALU_OP_W-1:0]   aluop_i,
   input  logic [ALU_SEL_W-1:0]  alusel_i,
   input  logic [REG_BUS_W-1:0]  reg1_i,
   input  logic [REG_BUS_W-1:0]  reg2_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic                  annul_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [REG_BUS_W-1:0]  wdata_o,
   output logic                  whilo_o,
   output logic [REG_BUS_W-1:0]  hi_o,
   output logic [REG_BUS_W-1:0]  lo_o,
   output logic                  stallreq_o
);

   logic [REG_BUS_W-1:0] sum;
   logic [REG_BUS_W-1:0] diff;
   logic                 ov_add;
   logic                 ov_sub;
   logic [REG_BUS_W-1:0] alu_res;
   logic                 wr_ok;
   logic                 is_div_op;
   logic [63:0]          div_result;
   hilo_t                div_hilo;
   logic                 div_ready;

   assign sum    = reg1_i + reg2_i;
   assign diff   = reg1_i - reg2_i;
   assign ov_add = (reg1_i[31] == reg2_i[31]) && (sum[31]  != reg1_i[31]);
   assign ov_sub = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);

   assign is_div_op = (alusel_i == SEL_DIV) &&
                      (aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP);

   // ALU result and GPR write permission; any unrecognised class/op pair writes nothing
   always_comb begin
      alu_res = ZERO_WORD;
      wr_ok   = 1'b0;
      case (alusel_i)
         SEL_NOP: begin
            if (aluop_i == EXE_NOP_OP) wr_ok = 1'b1;
         end
         SEL_LOGIC: begin
            case (aluop_i)
               EXE_OR_OP:  begin alu_res = reg1_i | reg2_i;    wr_ok = 1'b1; end
               EXE_AND_OP: begin alu_res = reg1_i & reg2_i;    wr_ok = 1'b1; end
               EXE_XOR_OP: begin alu_res = reg1_i ^ reg2_i;    wr_ok = 1'b1; end
               EXE_NOR_OP: begin alu_res = ~(reg1_i | reg2_i); wr_ok = 1'b1; end
               default: ;
            endcase
         end
         SEL_SHIFT: begin
            case (aluop_i)
               EXE_SLL_OP: begin alu_res = reg2_i << reg1_i[4:0]; wr_ok = 1'b1; end
               EXE_SRL_OP: begin alu_res = reg2_i >> reg1_i[4:0]; wr_ok = 1'b1; end
               EXE_SRA_OP: begin alu_res = $signed(reg2_i) >>> reg1_i[4:0]; wr_ok = 1'b1; end
               default: ;
            endcase
         end
         SEL_ARITH: begin
            case (aluop_i)
               EXE_ADD_OP:  begin alu_res = sum;  wr_ok = !ov_add; end
               EXE_ADDU_OP: begin alu_res = sum;  wr_ok = 1'b1;    end
               EXE_SUB_OP:  begin alu_res = diff; wr_ok = !ov_sub; end
               EXE_SUBU_OP: begin alu_res = diff; wr_ok = 1'b1;    end
               EXE_SLT_OP: begin
                  alu_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
                  wr_ok   = 1'b1;
               end
               EXE_SLTU_OP: begin
                  alu_res = {31'd0, (reg1_i < reg2_i)};
                  wr_ok   = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   div u_div (
      .clk      (clk),
      .rst      (rst),
      .signed_i (aluop_i == EXE_DIV_OP),
      .op1_i    (reg1_i),
      .op2_i    (reg2_i),
      .start_i  (is_div_op),
      .annul_i  (annul_i),
      .result_o (div_result),
      .ready_o  (div_ready)
   );

   assign div_hilo = div_result;

   // Write-back and stall outputs, all forced low while in reset
   always_comb begin
      wd_o       = rst ? '0 : wd_i;
      wreg_o     = !rst && wreg_i && wr_ok;
      wdata_o    = rst ? ZERO_WORD : alu_res;
      whilo_o    = !rst && is_div_op && (div_ready == DIV_RESULT_READY);
      hi_o       = whilo_o ? div_hilo.hi : ZERO_WORD;
      lo_o       = whilo_o ? div_hilo.lo : ZERO_WORD;
      stallreq_o = (!rst && is_div_op && !annul_i && div_ready == DIV_RESULT_NOT_READY)
                   ? STOP : NO_STOP;
   end

endmodule
